// File: rtl/jk_sequence_driver_pkg.sv
`default_nettype none
// ============================================================
// Module   : jk_defs (package)
// Brief    : FSM state encoding and J/K bit positions within a pair.
// Revision : 1.0
// ============================================================
package jk_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Each flop takes a {J,K} pair, J in the upper bit.
  localparam int c_J_POS = 1;
  localparam int c_K_POS = 0;

endpackage
`default_nettype wire

// File: rtl/jk_sequence_driver_if.sv
`default_nettype none
// ============================================================
// Module   : jk_sequence_driver_if
// Brief    : Control, sequence-write and flop-bank signals of the driver.
// Revision : 1.0
// ============================================================
interface jk_sequence_driver_if #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
);

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [ADDR_W-1:0]   last_idx;
  logic                loop;
  logic                start;
  logic                abort;
  logic [WIDTH-1:0]    q_in;
  logic [2*WIDTH-1:0]  jk_out;
  logic                busy;
  logic                done;
  logic                mismatch;
  logic [ADDR_W-1:0]   step_idx;

  modport master (
    output wr_en, wr_addr, wr_data, last_idx, loop, start, abort, q_in,
    input  jk_out, busy, done, mismatch, step_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, last_idx, loop, start, abort, q_in,
    output jk_out, busy, done, mismatch, step_idx
  );

endinterface
`default_nettype wire

// File: rtl/jk_sequence_driver_excitation.sv
`default_nettype none
// ============================================================
// Module   : jk_excitation
// Brief    : Per-bit JK excitation from current Q and target T.
// Revision : 1.0
// ============================================================
module jk_excitation
  import jk_defs::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   t,
  output logic [2*WIDTH-1:0] jk
);

  // Hold cases produce 00, so the pair is never 11 (no toggle).
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign jk[2*i + c_J_POS] = ~q[i] &  t[i];
    assign jk[2*i + c_K_POS] =  q[i] & ~t[i];
  end

endmodule
`default_nettype wire

// File: rtl/jk_sequence_driver.sv
`default_nettype none
// ============================================================
// Module   : jk_sequence_driver
// Brief    : Steps a JK flop bank through a stored sequence, checking each step.
// Revision : 1.0
// ============================================================
module jk_sequence_driver
  import jk_defs::*;
#(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clock,
  input  logic                clear_n,
  jk_sequence_driver_if.slave bus
);

  state_t               r_state;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_step_idx;
  logic [ADDR_W-1:0]    r_last_idx;
  logic                 r_loop;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mismatch;
  logic [2*WIDTH-1:0]   r_jk_out;

  logic                 w_at_last;
  logic [ADDR_W-1:0]    w_next_idx;
  logic [WIDTH-1:0]     w_target;
  logic [2*WIDTH-1:0]   w_jk;
  logic                 w_match;
  logic                 w_wr_ok;

  // After the last step the next index wraps to 0, which is only used when looping.
  assign w_at_last  = (r_step_idx == r_last_idx);
  assign w_next_idx = w_at_last ? '0 : r_step_idx + ADDR_W'(1);
  assign w_target   = (r_state == ST_CHECK) ? r_mem[w_next_idx] : r_mem[0];
  assign w_match    = (bus.q_in == r_mem[r_step_idx]);
  assign w_wr_ok    = (r_state == ST_IDLE) && bus.wr_en && !bus.start;

  jk_excitation #(
    .WIDTH (WIDTH)
  ) u_exc (
    .q  (bus.q_in),
    .t  (w_target),
    .jk (w_jk)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_jk_out   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_step_idx <= '0;
      r_last_idx <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_jk_out <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_step_idx <= '0;
            r_last_idx <= bus.last_idx;
            r_loop     <= bus.loop;
            r_mismatch <= 1'b0;
            r_jk_out   <= w_jk;
            r_busy     <= 1'b1;
            r_state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_busy  <= !bus.abort;
          r_state <= bus.abort ? ST_IDLE : ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!w_match) begin
            r_mismatch <= 1'b1;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (!w_at_last || r_loop) begin
            r_step_idx <= w_next_idx;
            r_jk_out   <= w_jk;
            r_state    <= ST_DRIVE;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.jk_out   = r_jk_out;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.mismatch = r_mismatch;
  assign bus.step_idx = r_step_idx;

endmodule
`default_nettype wire

// File: tb/tb_jk_sequence_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// Module   : tb_jk_sequence_driver
// Brief    : Bench for jk_sequence_driver with a 4-flop JK bank on jk_out/q_in.
// Revision : 1.0
// ============================================================
module tb_jk_sequence_driver;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;
  always #5 clock = ~clock;

  jk_sequence_driver_if #(.WIDTH(4), .ADDR_W(3)) bus ();

  jk_sequence_driver #(
    .WIDTH  (4),
    .DEPTH  (8),
    .ADDR_W (3)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  // JK flop bank; stuck_mask forces chosen bits low to inject a fault.
  logic [3:0] bank_q, bank_nq, bank_val, stuck_mask;
  logic       bank_load;

  always_comb begin
    bank_nq = bank_q;
    for (int i = 0; i < 4; i++) begin
      case ({bus.jk_out[2*i+1], bus.jk_out[2*i]})
        2'b10:   bank_nq[i] = 1'b1;
        2'b01:   bank_nq[i] = 1'b0;
        2'b11:   bank_nq[i] = ~bank_q[i];
        default: bank_nq[i] = bank_q[i];
      endcase
    end
  end

  always_ff @(posedge clock) bank_q <= bank_load ? bank_val : (bank_nq & ~stuck_mask);
  assign bus.q_in = bank_q;

  int total = 0;
  int bad   = 0;
  logic [3:0] model_mem [8];

  typedef struct {
    logic [3:0] q0;
    logic [3:0] t;
    logic [3:0] j;
    logic [3:0] k;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unpacks the interleaved bus into {J word, K word}.
  function automatic logic [7:0] split_jk(input logic [7:0] jk);
    logic [3:0] j, k;
    for (int i = 0; i < 4; i++) begin
      j[i] = jk[2*i+1];
      k[i] = jk[2*i];
    end
    return {j, k};
  endfunction

  function automatic logic [7:0] exp_jk(input logic [3:0] q, input logic [3:0] t);
    return {~q & t, q & ~t};
  endfunction

  task automatic write_mem(input logic [2:0] a, input logic [3:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clock);
    bus.wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic load_bank(input logic [3:0] v);
    bank_load = 1'b1; bank_val = v;
    @(negedge clock);
    bank_load = 1'b0;
  endtask

  // Non-looping run checked step by step against the sequence model.
  task automatic run_seq(input string tag, input logic [2:0] last, input bit poke, input bit wr_with_start);
    logic [3:0] q, t, qn;
    bit ended;
    q = bank_q;
    bus.start = 1'b1; bus.last_idx = last; bus.loop = 1'b0;
    if (wr_with_start) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'($urandom_range(0, 7)); bus.wr_data = 4'($urandom);
    end
    @(negedge clock);
    bus.start = 1'b0; bus.wr_en = 1'b0;
    ended = 1'b0;
    for (int k = 0; k <= int'(last) && !ended; k++) begin
      t = model_mem[k];
      check({tag, " drive jk"}, 32'(split_jk(bus.jk_out)), 32'(exp_jk(q, t)));
      check({tag, " drive busy"}, 32'(bus.busy), 1);
      check({tag, " drive step"}, 32'(bus.step_idx), k);
      if (poke && k == 0) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'hF;
      end
      @(negedge clock);
      bus.start = 1'b0; bus.wr_en = 1'b0;
      qn = t & ~stuck_mask;
      check({tag, " check jk"}, 32'(bus.jk_out), 0);
      check({tag, " check done"}, 32'(bus.done), 0);
      check({tag, " bank q"}, 32'(bank_q), 32'(qn));
      @(negedge clock);
      if (qn != t) begin
        check({tag, " mm done"}, 32'(bus.done), 1);
        check({tag, " mm flag"}, 32'(bus.mismatch), 1);
        check({tag, " mm step"}, 32'(bus.step_idx), k);
        check({tag, " mm busy"}, 32'(bus.busy), 0);
        ended = 1'b1;
      end else if (k == int'(last)) begin
        check({tag, " end done"}, 32'(bus.done), 1);
        check({tag, " end flag"}, 32'(bus.mismatch), 0);
        check({tag, " end busy"}, 32'(bus.busy), 0);
      end else begin
        check({tag, " mid done"}, 32'(bus.done), 0);
      end
      q = qn;
    end
    @(negedge clock);
    check({tag, " done pulse width"}, 32'(bus.done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
    vt[1] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    vt[2] = '{4'b1010, 4'b0110, 4'b0100, 4'b1000};
    vt[3] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000};
    vt[4] = '{4'b1100, 4'b0101, 4'b0001, 4'b1000};
    vt[5] = '{4'b0110, 4'b1001, 4'b1001, 4'b0110};

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.last_idx = '0;
    bus.loop = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bank_load = 1'b1; bank_val = 4'b0000; stuck_mask = 4'b0000;
    for (int i = 0; i < 8; i++) model_mem[i] = 4'b0000;

    repeat (2) @(negedge clock);
    check("reset jk", 32'(bus.jk_out), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset done", 32'(bus.done), 0);
    check("reset mismatch", 32'(bus.mismatch), 0);
    check("reset step", 32'(bus.step_idx), 0);
    clear_n = 1'b1;
    bank_load = 1'b0;
    @(negedge clock);

    // Single-step excitation table.
    for (int i = 0; i < 6; i++) begin
      write_mem(3'd0, vt[i].t);
      load_bank(vt[i].q0);
      bus.start = 1'b1; bus.last_idx = 3'd0; bus.loop = 1'b0;
      @(negedge clock);
      bus.start = 1'b0;
      check($sformatf("table%0d jk", i), 32'(split_jk(bus.jk_out)), 32'({vt[i].j, vt[i].k}));
      @(negedge clock);
      @(negedge clock);
      check($sformatf("table%0d done", i), 32'(bus.done), 1);
      check($sformatf("table%0d q", i), 32'(bank_q), 32'(vt[i].t));
      check($sformatf("table%0d mismatch", i), 32'(bus.mismatch), 0);
    end

    // Four-step counting-up sequence.
    write_mem(3'd0, 4'b0001); write_mem(3'd1, 4'b0011);
    write_mem(3'd2, 4'b0111); write_mem(3'd3, 4'b1111);
    load_bank(4'b0000);
    run_seq("seq4", 3'd3, 1'b0, 1'b0);
    check("seq4 final q", 32'(bank_q), 32'hF);

    // Bit 2 held low: fails at step 2 and the flag stays set while idle.
    load_bank(4'b0000);
    stuck_mask = 4'b0100;
    run_seq("stuck", 3'd3, 1'b0, 1'b0);
    stuck_mask = 4'b0000;
    @(negedge clock);
    check("stuck sticky", 32'(bus.mismatch), 1);
    check("stuck step held", 32'(bus.step_idx), 2);

    // Looping two-entry sequence, then abort from DRIVE.
    write_mem(3'd0, 4'b0101); write_mem(3'd1, 4'b1010);
    load_bank(4'b0000);
    bus.start = 1'b1; bus.last_idx = 3'd1; bus.loop = 1'b1;
    @(negedge clock);
    bus.start = 1'b0; bus.loop = 1'b0;
    for (int s = 0; s < 6; s++) begin
      logic [3:0] qb, tt;
      tt = model_mem[s % 2];
      qb = (s == 0) ? 4'b0000 : model_mem[(s + 1) % 2];
      check($sformatf("loop%0d jk", s), 32'(split_jk(bus.jk_out)), 32'(exp_jk(qb, tt)));
      check($sformatf("loop%0d step", s), 32'(bus.step_idx), s % 2);
      @(negedge clock);
      check($sformatf("loop%0d q", s), 32'(bank_q), 32'(tt));
      check($sformatf("loop%0d done", s), 32'(bus.done), 0);
      @(negedge clock);
    end
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort busy", 32'(bus.busy), 0);
    check("abort jk", 32'(bus.jk_out), 0);
    check("abort done", 32'(bus.done), 0);
    check("abort mismatch", 32'(bus.mismatch), 0);
    @(negedge clock);
    check("abort no late done", 32'(bus.done), 0);
    check("abort stays idle", 32'(bus.busy), 0);

    // start and write while busy are both ignored.
    write_mem(3'd0, 4'b0001); write_mem(3'd1, 4'b0011);
    write_mem(3'd2, 4'b0111); write_mem(3'd3, 4'b1111);
    load_bank(4'b0000);
    run_seq("busy poke", 3'd3, 1'b1, 1'b0);
    load_bank(4'b0000);
    run_seq("after poke", 3'd0, 1'b0, 1'b0);

    // Randomised runs; some also present a write alongside start, which must be dropped.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) write_mem(3'($urandom_range(0, 7)), 4'($urandom));
      load_bank(4'($urandom));
      stuck_mask = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      run_seq($sformatf("rand%0d", it), 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)));
      stuck_mask = 4'b0000;
    end

    // Reset during DRIVE clears outputs at once and empties the memory.
    write_mem(3'd0, 4'b1010);
    load_bank(4'b0101);
    bus.start = 1'b1; bus.last_idx = 3'd0;
    @(negedge clock);
    bus.start = 1'b0;
    check("pre-reset jk", 32'(split_jk(bus.jk_out)), 32'(exp_jk(4'b0101, 4'b1010)));
    #2 clear_n = 1'b0;
    #1;
    check("async reset jk", 32'(bus.jk_out), 0);
    check("async reset busy", 32'(bus.busy), 0);
    check("async reset mismatch", 32'(bus.mismatch), 0);
    @(negedge clock);
    clear_n = 1'b1;
    for (int i = 0; i < 8; i++) model_mem[i] = 4'b0000;
    check("bank untouched by reset", 32'(bank_q), 32'h5);
    run_seq("post reset", 3'd7, 1'b0, 1'b0);
    check("post reset q", 32'(bank_q), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
